// File: rtl/acc_bank.sv
// acc_bank: multi-column, multi-entry accumulator bank.
// Each accepted beat either overwrites (in_first) or adds into one register-file
// entry per lane. A beat flagged in_last hands the finished row to a
// valid/ready output register and zeroes the entry so the next tile starts clean.
// Overflow is detected on the ACC_W+1 bit sum; it either clamps (SAT=1) or
// wraps (SAT=0), and it always sets a sticky per-lane flag.
module acc_bank #(
    parameter int N_COL  = 16,
    parameter int PSUM_W = 32,
    parameter int ACC_W  = 32,
    parameter int DEPTH  = 16,
    parameter int SAT    = 1
) (
    input  logic                         clk,
    input  logic                         nRST,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_COL*PSUM_W-1:0]      in_psum,
    input  logic [$clog2(DEPTH)-1:0]     in_addr,
    input  logic                         in_first,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH)-1:0]     out_addr,
    output logic [N_COL*ACC_W-1:0]       out_data,
    output logic [N_COL-1:0]             ovf
);

    localparam int AW = $clog2(DEPTH);

    // Narrow an ACC_W+1 bit sum back to ACC_W bits. When the two top bits
    // disagree the true result is out of range: clamp toward its sign when
    // saturating, otherwise keep the low bits (two's-complement wrap).
    function automatic logic [ACC_W-1:0] resolve_fn(input logic [ACC_W:0] sum);
        logic [ACC_W-1:0] r;
        r = sum[ACC_W-1:0];
        if ((sum[ACC_W] != sum[ACC_W-1]) && (SAT != 32'sd0)) begin
            if (sum[ACC_W]) begin
                r = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                r = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            r = sum[ACC_W-1:0];
        end
        return r;
    endfunction

    logic                   accept_s;
    logic                   load_out_s;
    logic                   drain_s;
    logic [N_COL*ACC_W-1:0] new_data_s;
    logic [N_COL-1:0]       lane_ovf_s;

    // A full output register that is not being taken stalls every beat, and
    // clear always wins; a drain in the same cycle frees the register.
    assign in_ready   = !clear && !(out_valid && !out_ready);
    assign accept_s   = in_valid && in_ready;
    assign load_out_s = accept_s && in_last;
    assign drain_s    = out_valid && out_ready;

    for (genvar c = 0; c < N_COL; c++) begin : g_lane
        logic [ACC_W-1:0] mem_r [DEPTH];
        logic [ACC_W-1:0] cur_s;
        logic [ACC_W:0]   operand_s;
        logic [ACC_W:0]   base_s;
        logic [ACC_W:0]   sum_s;

        assign cur_s = mem_r[in_addr];

        // Sign-extend the lane operand and the stored value into ACC_W+1 bits and
        // add; an in_first beat adds to zero, so it can never overflow.
        always_comb begin
            operand_s = {{(ACC_W+1-PSUM_W){in_psum[c*PSUM_W+PSUM_W-1]}},
                         in_psum[c*PSUM_W +: PSUM_W]};
            if (in_first) begin
                base_s = {(ACC_W+1){1'b0}};
            end else begin
                base_s = {cur_s[ACC_W-1], cur_s};
            end
            sum_s = base_s + operand_s;
        end

        assign lane_ovf_s[c]                 = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        assign new_data_s[c*ACC_W +: ACC_W]  = resolve_fn(sum_s);

        // Entry storage for this lane: write-back of the new sum, or zero on the
        // closing beat so the next tile needs no in_first.
        always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem_r[d] <= {ACC_W{1'b0}};
                end
            end else if (clear) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem_r[d] <= {ACC_W{1'b0}};
                end
            end else if (accept_s) begin
                if (in_last) begin
                    mem_r[in_addr] <= {ACC_W{1'b0}};
                end else begin
                    mem_r[in_addr] <= new_data_s[c*ACC_W +: ACC_W];
                end
            end
        end
    end

    // Output register: reload on a closing beat (also when draining in the same
    // cycle, so there is no bubble), otherwise release on handshake.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            out_valid <= 1'b0;
            out_addr  <= {AW{1'b0}};
            out_data  <= {(N_COL*ACC_W){1'b0}};
        end else if (clear) begin
            out_valid <= 1'b0;
            out_addr  <= {AW{1'b0}};
            out_data  <= {(N_COL*ACC_W){1'b0}};
        end else if (load_out_s) begin
            out_valid <= 1'b1;
            out_addr  <= in_addr;
            out_data  <= new_data_s;
        end else if (drain_s) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky per-lane overflow flags, cleared only by clear or reset.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ovf <= {N_COL{1'b0}};
        end else if (clear) begin
            ovf <= {N_COL{1'b0}};
        end else if (accept_s) begin
            ovf <= ovf | lane_ovf_s;
        end
    end

endmodule

// File: tb/tb_acc_bank.sv
// Directed testbench for acc_bank: a saturating 16-lane instance and a
// wrapping 2-lane instance share the control stimulus.
module tb_acc_bank;

    localparam int N  = 16;
    localparam int PW = 32;
    localparam int AW = 32;

    logic              clk;
    logic              nRST;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [N*PW-1:0]   in_psum;
    logic [3:0]        in_addr;
    logic              in_first;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_addr;
    logic [N*AW-1:0]   out_data;
    logic [N-1:0]      ovf;

    logic              w_in_ready;
    logic              w_out_valid;
    logic [3:0]        w_out_addr;
    logic [2*AW-1:0]   w_out_data;
    logic [1:0]        w_ovf;

    int vecs;
    int errs;
    logic [N*AW-1:0] exp_v;
    logic [N*PW-1:0] p_v;

    acc_bank #(.N_COL(N), .PSUM_W(PW), .ACC_W(AW), .DEPTH(16), .SAT(1)) dut (
        .clk(clk), .nRST(nRST), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
        .in_addr(in_addr), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .ovf(ovf)
    );

    acc_bank #(.N_COL(2), .PSUM_W(PW), .ACC_W(AW), .DEPTH(16), .SAT(0)) dut_w (
        .clk(clk), .nRST(nRST), .clear(clear),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_psum(in_psum[2*PW-1:0]),
        .in_addr(in_addr), .in_first(in_first), .in_last(in_last),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_addr(w_out_addr),
        .out_data(w_out_data), .ovf(w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*PW-1:0] rep(input logic [31:0] v);
        logic [N*PW-1:0] r;
        for (int i = 0; i < N; i++) r[i*PW +: PW] = v;
        return r;
    endfunction

    // One accepted beat: inputs driven away from the edge, checks follow at edge+1.
    task automatic beat(input logic [3:0] a, input logic [N*PW-1:0] p,
                        input logic f, input logic l);
        in_valid = 1'b1; in_addr = a; in_psum = p; in_first = f; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        vecs++; if (out_addr !== 4'd0) begin errs++; $display("FAIL rst_out_addr got %0d exp 0", out_addr); end
        vecs++; if (out_data !== {(N*AW){1'b0}}) begin errs++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        vecs++; if (ovf !== 16'h0000) begin errs++; $display("FAIL rst_ovf got %h exp 0", ovf); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        vecs++; if (w_in_ready !== 1'b1) begin errs++; $display("FAIL rst_w_in_ready got %b exp 1", w_in_ready); end
    endtask

    task automatic test_basic();
        beat(4'd3, rep(32'd5), 1'b1, 1'b0);
        beat(4'd3, rep(32'd7), 1'b0, 1'b0);
        beat(4'd3, rep(32'hFFFF_FFFE), 1'b0, 1'b1);
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        vecs++; if (out_addr !== 4'd3) begin errs++; $display("FAIL basic_addr got %0d exp 3", out_addr); end
        vecs++; if (out_data !== rep(32'd10)) begin errs++; $display("FAIL basic_data got %h exp %h", out_data, rep(32'd10)); end
        // entry 3 must have been zeroed by the closing beat
        beat(4'd3, rep(32'd0), 1'b0, 1'b1);
        vecs++; if (out_data !== rep(32'd0)) begin errs++; $display("FAIL basic_entry_zero got %h exp 0", out_data); end
        @(posedge clk); #1;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 8; i++) begin
            beat((i % 2 == 1) ? 4'd1 : 4'd0, rep((i % 2 == 1) ? 32'd100 : 32'd1),
                 (i < 2) ? 1'b1 : 1'b0, (i >= 6) ? 1'b1 : 1'b0);
            if (i == 6) begin
                vecs++; if (out_addr !== 4'd0 || out_valid !== 1'b1) begin errs++; $display("FAIL il_addr0 got %0d/%b exp 0/1", out_addr, out_valid); end
                vecs++; if (out_data !== rep(32'd4)) begin errs++; $display("FAIL il_data0 got %h exp %h", out_data, rep(32'd4)); end
            end
            if (i == 7) begin
                vecs++; if (out_addr !== 4'd1 || out_valid !== 1'b1) begin errs++; $display("FAIL il_addr1 got %0d/%b exp 1/1", out_addr, out_valid); end
                vecs++; if (out_data !== rep(32'd400)) begin errs++; $display("FAIL il_data1 got %h exp %h", out_data, rep(32'd400)); end
            end
        end
    endtask

    task automatic test_saturation();
        pulse_clear();
        p_v = {(N*PW){1'b0}};
        p_v[31:0] = 32'h7FFF_FFF0; p_v[63:32] = 32'h8000_0005;
        beat(4'd5, p_v, 1'b1, 1'b0);
        vecs++; if (ovf !== 16'h0000) begin errs++; $display("FAIL sat_first_no_ovf got %h exp 0", ovf); end
        p_v[31:0] = 32'h0000_0020; p_v[63:32] = 32'hFFFF_FFF0;
        beat(4'd5, p_v, 1'b0, 1'b1);
        exp_v = {(N*AW){1'b0}};
        exp_v[31:0] = 32'h7FFF_FFFF; exp_v[63:32] = 32'h8000_0000;
        vecs++; if (out_data !== exp_v) begin errs++; $display("FAIL sat_data got %h exp %h", out_data[63:0], exp_v[63:0]); end
        vecs++; if (ovf !== 16'h0003) begin errs++; $display("FAIL sat_ovf got %h exp 0003", ovf); end
        vecs++; if (w_out_data !== 64'h7FFF_FFF5_8000_0010) begin errs++; $display("FAIL wrap_data got %h exp 7ffffff580000010", w_out_data); end
        vecs++; if (w_ovf !== 2'b11) begin errs++; $display("FAIL wrap_ovf got %b exp 11", w_ovf); end
        vecs++; if (w_out_valid !== 1'b1 || w_out_addr !== 4'd5) begin errs++; $display("FAIL wrap_out got %b/%0d exp 1/5", w_out_valid, w_out_addr); end
    endtask

    task automatic test_backpressure();
        pulse_clear();
        out_ready = 1'b0;
        beat(4'd2, rep(32'd9), 1'b1, 1'b1);
        vecs++; if (out_valid !== 1'b1 || out_addr !== 4'd2) begin errs++; $display("FAIL bp_load got %b/%0d exp 1/2", out_valid, out_addr); end
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_addr = 4'd4; in_psum = rep(32'd1); in_first = 1'b1; in_last = 1'b0;
            #1;
            vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
            @(posedge clk); #1;
            vecs++; if (out_data !== rep(32'd9) || out_valid !== 1'b1 || out_addr !== 4'd2) begin errs++; $display("FAIL bp_hold got %h/%b exp %h/1", out_data, out_valid, rep(32'd9)); end
        end
        in_psum = rep(32'd6); in_first = 1'b0; in_last = 1'b1; out_ready = 1'b1;
        #1;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        vecs++; if (out_valid !== 1'b1 || out_addr !== 4'd4) begin errs++; $display("FAIL bp_reload got %b/%0d exp 1/4", out_valid, out_addr); end
        vecs++; if (out_data !== rep(32'd6)) begin errs++; $display("FAIL bp_reload_data got %h exp %h", out_data, rep(32'd6)); end
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        beat(4'd7, rep(32'd50), 1'b1, 1'b0);
        p_v = {(N*PW){1'b0}}; p_v[31:0] = 32'h7FFF_FFFF;
        beat(4'd6, p_v, 1'b1, 1'b0);
        p_v[31:0] = 32'h0000_0001;
        beat(4'd6, p_v, 1'b0, 1'b1);
        out_ready = 1'b0;
        vecs++; if (ovf !== 16'h0001 || out_valid !== 1'b1) begin errs++; $display("FAIL clr_pre got %h/%b exp 0001/1", ovf, out_valid); end
        clear = 1'b1; in_valid = 1'b1; in_addr = 4'd7; in_psum = rep(32'd5); in_first = 1'b0; in_last = 1'b1;
        #1;
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL clr_in_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL clr_out_valid got %b exp 0", out_valid); end
        vecs++; if (ovf !== 16'h0000) begin errs++; $display("FAIL clr_ovf got %h exp 0", ovf); end
        vecs++; if (out_data !== {(N*AW){1'b0}} || out_addr !== 4'd0) begin errs++; $display("FAIL clr_out_reg got %h/%0d exp 0/0", out_data, out_addr); end
        out_ready = 1'b1;
        beat(4'd7, rep(32'd0), 1'b0, 1'b1);
        vecs++; if (out_data !== rep(32'd0) || out_valid !== 1'b1) begin errs++; $display("FAIL clr_entry got %h/%b exp 0/1", out_data, out_valid); end
    endtask

    task automatic test_async_reset();
        beat(4'd8, rep(32'd3), 1'b1, 1'b0);
        beat(4'd8, rep(32'd4), 1'b0, 1'b0);
        out_ready = 1'b0;
        beat(4'd9, rep(32'd1), 1'b1, 1'b1);
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL ar_pre got %b exp 1", out_valid); end
        #3 nRST = 1'b0;
        #1;
        vecs++; if (out_valid !== 1'b0 || out_addr !== 4'd0) begin errs++; $display("FAIL ar_out got %b/%0d exp 0/0", out_valid, out_addr); end
        vecs++; if (out_data !== {(N*AW){1'b0}} || ovf !== 16'h0000) begin errs++; $display("FAIL ar_data got %h/%h exp 0/0", out_data, ovf); end
        #1 nRST = 1'b1;
        out_ready = 1'b1;
        beat(4'd8, rep(32'd2), 1'b0, 1'b0);
        beat(4'd8, rep(32'd5), 1'b0, 1'b1);
        vecs++; if (out_data !== rep(32'd7) || out_addr !== 4'd8) begin errs++; $display("FAIL ar_fresh got %h/%0d exp %h/8", out_data, out_addr, rep(32'd7)); end
    endtask

    initial begin
        vecs = 0; errs = 0;
        nRST = 1'b0; clear = 1'b0; in_valid = 1'b0; in_psum = {(N*PW){1'b0}};
        in_addr = 4'd0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        #12 nRST = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_interleave();
        test_saturation();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
